// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    localparam int PC_WIDTH        = 7;
    localparam int INSTR_WIDTH     = 9;
    localparam int LUT_INDEX_WIDTH = 4;
    localparam int LUT_DEPTH       = 1 << LUT_INDEX_WIDTH;

    typedef logic [PC_WIDTH-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/branch_target_lut.sv
// Branch-target register file: one synchronous write port, one combinational
// read port, asynchronous clear. A same-cycle write is seen by readers next cycle.
module branch_target_lut
    import fetch_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic [LUT_INDEX_WIDTH-1:0] waddr,
    input  logic [PC_WIDTH-1:0]        wdata,
    input  logic [LUT_INDEX_WIDTH-1:0] raddr,
    output logic [PC_WIDTH-1:0]        rdata
);

    logic [LUT_DEPTH-1:0][PC_WIDTH-1:0] entries;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entries <= '0;
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[raddr];

endmodule

// File: rtl/program_counter_fetch.sv
// Instruction-fetch front end: PC, launch/halt FSM, branch redirect through a
// writable target LUT, and a 1-cycle-latency synchronous instruction memory.
module program_counter_fetch
    import fetch_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [PC_WIDTH-1:0]        start_address,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [LUT_INDEX_WIDTH-1:0] branch_index,
    input  logic                       halt,
    input  logic                       lut_we,
    input  logic [LUT_INDEX_WIDTH-1:0] lut_waddr,
    input  logic [PC_WIDTH-1:0]        lut_wdata,
    output logic [PC_WIDTH-1:0]        imem_addr,
    input  logic [INSTR_WIDTH-1:0]     imem_rdata,
    output logic [INSTR_WIDTH-1:0]     instr,
    output logic [PC_WIDTH-1:0]        instr_pc,
    output logic                       instr_valid,
    output logic                       done
);

    fetch_state_t state, state_next;
    pc_t          pc, pc_next, instr_pc_next, lut_target;
    logic         valid_next, done_next;
    logic         fire_halt, fire_branch;

    branch_target_lut u_lut (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (lut_we),
        .waddr   (lut_waddr),
        .wdata   (lut_wdata),
        .raddr   (branch_index),
        .rdata   (lut_target)
    );

    // halt/branch only qualify a presented (valid) instruction; halt wins
    assign fire_halt   = (state == RUN) && instr_valid && halt;
    assign fire_branch = (state == RUN) && instr_valid && branch_taken && !halt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALTED: if (start) state_next = RUN;
            RUN:          if (fire_halt) state_next = HALTED;
            default:      state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_next       = pc;
        instr_pc_next = instr_pc;
        valid_next    = instr_valid;
        done_next     = done;
        case (state)
            IDLE, HALTED: begin
                valid_next = 1'b0;
                if (start) begin
                    pc_next   = start_address;
                    done_next = 1'b0;
                end
            end
            RUN: begin
                if (fire_halt) begin
                    done_next  = 1'b1;
                    valid_next = 1'b0;
                end else if (fire_branch) begin
                    pc_next    = lut_target;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    pc_next       = pc + pc_t'(1);
                    instr_pc_next = pc;
                    valid_next    = 1'b1;
                end
            end
            default: valid_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            pc          <= pc_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= valid_next;
            done        <= done_next;
        end
    end

    // pc already points one past the presented word, so a stall must re-read
    // instr_pc to keep the memory output (and instr) stable.
    assign imem_addr = (state == RUN && stall && instr_valid) ? instr_pc : pc;
    assign instr     = imem_rdata;

endmodule

// File: tb/tb_program_counter_fetch.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a transaction-level model of the fetch rules.
module tb_program_counter_fetch;

    localparam int PW = 7;
    localparam int IW = 9;
    localparam int LW = 4;

    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, stall, branch_taken, halt, lut_we;
    logic [PW-1:0] start_address, lut_wdata, imem_addr, instr_pc;
    logic [LW-1:0] branch_index, lut_waddr;
    logic [IW-1:0] imem_rdata, instr;
    logic          instr_valid, done;

    logic [IW-1:0] mem [128];

    mstate_t m_state;
    logic    m_valid, m_done;
    int      m_pc, m_next;
    int      m_lut [16];
    int      chk_total = 0;
    int      chk_pass  = 0;

    program_counter_fetch dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .start_address (start_address),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_index  (branch_index),
        .halt          (halt),
        .lut_we        (lut_we),
        .lut_waddr     (lut_waddr),
        .lut_wdata     (lut_wdata),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .done          (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_rdata <= mem[imem_addr];

    // Model: m_next is the address the next presented instruction will carry;
    // m_pc/m_valid describe what is presented now.
    task automatic model_reset();
        m_state = M_IDLE;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_pc    = 0;
        m_next  = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    task automatic model_step();
        case (m_state)
            M_IDLE, M_HALT: begin
                if (start) begin
                    m_state = M_RUN;
                    m_done  = 1'b0;
                    m_valid = 1'b0;
                    m_next  = int'(start_address);
                end
            end
            M_RUN: begin
                if (m_valid && halt) begin
                    m_state = M_HALT;
                    m_done  = 1'b1;
                    m_valid = 1'b0;
                end else if (m_valid && branch_taken) begin
                    m_valid = 1'b0;
                    m_next  = m_lut[branch_index];
                end else if (!stall) begin
                    m_pc    = m_next;
                    m_next  = (m_next + 1) % 128;
                    m_valid = 1'b1;
                end
            end
            default: ;
        endcase
        if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    endtask

    function automatic int exp_addr();
        return (m_state == M_RUN && stall && m_valid) ? m_pc : m_next;
    endfunction

    task automatic drive(input logic st, input int sa, input logic sl, input logic br,
                         input int bi, input logic h, input logic we, input int wa, input int wd);
        start         = st;
        start_address = PW'(sa);
        stall         = sl;
        branch_taken  = br;
        branch_index  = LW'(bi);
        halt          = h;
        lut_we        = we;
        lut_waddr     = LW'(wa);
        lut_wdata     = PW'(wd);
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #20;
        chk_total++;
        if (imem_addr !== '0 || instr_valid !== 1'b0 || done !== 1'b0 || instr_pc !== '0)
            $display("FAIL reset_hold: addr=%0d valid=%0b done=%0b ipc=%0d, want 0 0 0 0",
                     imem_addr, instr_valid, done, instr_pc);
        else chk_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk_total++;
            if (instr_valid !== 1'b0 || done !== 1'b0 || imem_addr !== '0)
                $display("FAIL reset_idle c%0d: valid=%0b done=%0b addr=%0d, want 0 0 0",
                         c, instr_valid, done, imem_addr);
            else chk_pass++;
            step();
        end
    endtask

    task automatic test_sequential();
        int first_valid = -1;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(1, 34, 0, 0, 0, 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (instr_valid === 1'b1 && first_valid < 0) first_valid = c;
            chk_total++;
            if (instr_valid !== m_valid || done !== m_done || imem_addr !== PW'(exp_addr()))
                $display("FAIL seq_ctl c%0d: valid=%0b done=%0b addr=%0d, want %0b %0b %0d",
                         c, instr_valid, done, imem_addr, m_valid, m_done, exp_addr());
            else chk_pass++;
            if (m_valid) begin
                chk_total++;
                if (instr_pc !== PW'(m_pc) || instr !== mem[PW'(m_pc)])
                    $display("FAIL seq_data c%0d: pc=%0d instr=%0h, want %0d %0h",
                             c, instr_pc, instr, m_pc, mem[PW'(m_pc)]);
                else chk_pass++;
            end
            step();
        end
        chk_total++;
        if (first_valid != 2) $display("FAIL seq_latency: first valid at %0d, want 2", first_valid);
        else chk_pass++;
    endtask

    task automatic test_stall();
        logic [IW-1:0] i0;
        logic [PW-1:0] a0;
        chk_total++;
        if (instr_pc !== 7'd40 || instr_valid !== 1'b1)
            $display("FAIL stall_pre: pc=%0d valid=%0b, want 40 1", instr_pc, instr_valid);
        else chk_pass++;
        i0 = instr;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, c < 3, 0, 0, 0, 0, 0, 0);
            if (c == 0) a0 = imem_addr;
            chk_total++;
            if (instr_valid !== m_valid || done !== m_done || imem_addr !== PW'(exp_addr()))
                $display("FAIL stall_ctl c%0d: valid=%0b done=%0b addr=%0d, want %0b %0b %0d",
                         c, instr_valid, done, imem_addr, m_valid, m_done, exp_addr());
            else chk_pass++;
            if (c < 3) begin
                chk_total++;
                if (instr_pc !== 7'd40 || instr !== i0 || instr_valid !== 1'b1 || imem_addr !== a0)
                    $display("FAIL stall_hold c%0d: pc=%0d instr=%0h addr=%0d, want 40 %0h %0d",
                             c, instr_pc, instr, imem_addr, i0, a0);
                else chk_pass++;
            end
            step();
        end
        chk_total++;
        if (instr_pc !== 7'd41 || instr_valid !== 1'b1 || instr !== mem[41])
            $display("FAIL stall_resume: pc=%0d valid=%0b, want 41 1", instr_pc, instr_valid);
        else chk_pass++;
    endtask

    task automatic test_branch();
        for (int c = 0; c < 14; c++) begin
            if (c == 9) begin
                chk_total++;
                if (instr_pc !== 7'd50 || instr_valid !== 1'b1)
                    $display("FAIL br_pre: pc=%0d, want 50", instr_pc);
                else chk_pass++;
            end
            if (c == 10) begin
                chk_total++;
                if (instr_valid !== 1'b0) $display("FAIL br_squash: valid=%0b, want 0", instr_valid);
                else chk_pass++;
            end
            if (c == 11 || c == 13) begin
                chk_total++;
                if (instr_pc !== ((c == 11) ? 7'd100 : 7'd110) || instr_valid !== 1'b1)
                    $display("FAIL br_target c%0d: pc=%0d valid=%0b, want %0d 1",
                             c, instr_pc, instr_valid, (c == 11) ? 100 : 110);
                else chk_pass++;
            end
            case (c)
                0:       drive(0, 0, 0, 0, 0, 0, 1, 5, 100);
                9:       drive(0, 0, 0, 1, 5, 0, 1, 5, 110);
                11:      drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            chk_total++;
            if (instr_valid !== m_valid || done !== m_done || imem_addr !== PW'(exp_addr()))
                $display("FAIL br_ctl c%0d: valid=%0b done=%0b addr=%0d, want %0b %0b %0d",
                         c, instr_valid, done, imem_addr, m_valid, m_done, exp_addr());
            else chk_pass++;
            if (m_valid) begin
                chk_total++;
                if (instr_pc !== PW'(m_pc) || instr !== mem[PW'(m_pc)])
                    $display("FAIL br_data c%0d: pc=%0d instr=%0h, want %0d %0h",
                             c, instr_pc, instr, m_pc, mem[PW'(m_pc)]);
                else chk_pass++;
            end
            step();
        end
    endtask

    task automatic test_wrap_halt();
        int wexp [4] = '{126, 127, 0, 1};
        for (int c = 0; c < 14; c++) begin
            if (c == 1 || (c >= 4 && c <= 7) || c == 13) begin
                chk_total++;
                if (instr_valid !== 1'b1 || instr_pc !== ((c == 1) ? 7'd112 : (c == 13) ? 7'd10 : PW'(wexp[(c - 4) & 3])))
                    $display("FAIL wrap_seq c%0d: pc=%0d valid=%0b", c, instr_pc, instr_valid);
                else chk_pass++;
            end
            if (c == 2 || c == 8) begin
                chk_total++;
                if (done !== 1'b1 || instr_valid !== 1'b0)
                    $display("FAIL halt_done c%0d: done=%0b valid=%0b, want 1 0", c, done, instr_valid);
                else chk_pass++;
            end
            if (c == 3 || c == 12) begin
                chk_total++;
                if (done !== 1'b0) $display("FAIL restart_done c%0d: done=%0b, want 0", c, done);
                else chk_pass++;
            end
            case (c)
                0:        drive(1, 10, 0, 0, 0, 0, 0, 0, 0);
                1, 7:     drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
                2:        drive(1, 126, 0, 0, 0, 0, 0, 0, 0);
                8, 9, 10: drive(0, 0, 1, 1, c, 1, 0, 0, 0);
                11:       drive(1, 10, 0, 0, 0, 0, 0, 0, 0);
                default:  drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            if (c == 9) begin
                chk_total++;
                if (imem_addr !== 7'd2) $display("FAIL halt_frozen: addr=%0d, want 2", imem_addr);
                else chk_pass++;
            end
            chk_total++;
            if (instr_valid !== m_valid || done !== m_done || imem_addr !== PW'(exp_addr()))
                $display("FAIL wrap_ctl c%0d: valid=%0b done=%0b addr=%0d, want %0b %0b %0d",
                         c, instr_valid, done, imem_addr, m_valid, m_done, exp_addr());
            else chk_pass++;
            step();
        end
    endtask

    task automatic test_reset_midrun();
        for (int c = 0; c < 49; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        chk_total++;
        if (instr_pc !== 7'd60 || instr_valid !== 1'b1)
            $display("FAIL mid_pre: pc=%0d, want 60", instr_pc);
        else chk_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk_total++;
        if (instr_valid !== 1'b0 || done !== 1'b0 || imem_addr !== '0 || instr_pc !== '0)
            $display("FAIL mid_reset: valid=%0b done=%0b addr=%0d ipc=%0d, want 0 0 0 0",
                     instr_valid, done, imem_addr, instr_pc);
        else chk_pass++;
        model_reset();
        #2 reset_n = 1'b1;
        step();
        for (int c = 0; c < 7; c++) begin
            if (c == 2 || c == 6) begin
                chk_total++;
                if (instr_valid !== 1'b1 || instr_pc !== ((c == 2) ? 7'd34 : 7'd0))
                    $display("FAIL mid_restart c%0d: pc=%0d valid=%0b, want %0d 1",
                             c, instr_pc, instr_valid, (c == 2) ? 34 : 0);
                else chk_pass++;
            end
            case (c)
                0:       drive(1, 34, 0, 0, 0, 0, 0, 0, 0);
                4:       drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            chk_total++;
            if (instr_valid !== m_valid || done !== m_done || imem_addr !== PW'(exp_addr()))
                $display("FAIL mid_ctl c%0d: valid=%0b done=%0b addr=%0d, want %0b %0b %0d",
                         c, instr_valid, done, imem_addr, m_valid, m_done, exp_addr());
            else chk_pass++;
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom % 12 == 0, int'($urandom_range(127)), $urandom % 4 == 0,
                  $urandom % 6 == 0, int'($urandom_range(15)), $urandom % 25 == 0,
                  $urandom % 5 == 0, int'($urandom_range(15)), int'($urandom_range(127)));
            chk_total++;
            if (instr_valid !== m_valid || done !== m_done || imem_addr !== PW'(exp_addr()))
                $display("FAIL rnd_ctl c%0d: valid=%0b done=%0b addr=%0d, want %0b %0b %0d",
                         c, instr_valid, done, imem_addr, m_valid, m_done, exp_addr());
            else chk_pass++;
            if (m_valid) begin
                chk_total++;
                if (instr_pc !== PW'(m_pc) || instr !== mem[PW'(m_pc)])
                    $display("FAIL rnd_data c%0d: pc=%0d instr=%0h, want %0d %0h",
                             c, instr_pc, instr, m_pc, mem[PW'(m_pc)]);
                else chk_pass++;
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = IW'($urandom);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap_halt();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", chk_pass, chk_total);
        $fatal(1, "watchdog");
    end

endmodule
